sad_min_tracker: RTL and testbench

- Sequential stage directly downstream of the 14-to-7 SAD compare stage.
- Each cycle it accepts the seven surviving SAD/index pairs as one beat and reduces them to a single minimum.
- It keeps a running best across all beats of one search window.
- At end of window it reports the winning SAD and its candidate index to the motion-vector output logic.

---
 rtl/vbsme_pkg.sv | 13 +
 rtl/sad_min_tree7.sv | 29 ++
 rtl/sad_min_tracker.sv | 138 +++++++++++++
 tb/tb_sad_min_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vbsme_pkg.sv
// Shared constants and state encoding for the SAD minimum search.
package vbsme_pkg;
  localparam int DW    = 32;
  localparam int LANES = 7;
  localparam int CNT_W = 16;
  localparam logic [DW-1:0] SAD_MAX = {DW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/sad_min_tree7.sv
// Combinational 7-to-1 SAD minimum with per-lane enables; ties go to the lower lane.
module sad_min_tree7
  import vbsme_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [LANES*W-1:0] sad_bus,
  input  logic [LANES*W-1:0] idx_bus,
  input  logic [LANES-1:0]   lane_en,
  output logic [W-1:0]       min_sad,
  output logic [W-1:0]       min_idx,
  output logic               any_en
);

  // Enable-aware compare: an enabled all-ones SAD still beats "nothing seen yet".
  always_comb begin
    min_sad = {W{1'b1}};
    min_idx = '0;
    any_en  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k] && (!any_en || (sad_bus[k*W +: W] < min_sad))) begin
        min_sad = sad_bus[k*W +: W];
        min_idx = idx_bus[k*W +: W];
        any_en  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Running-minimum tracker over one search window of 7-lane SAD beats.
// Beat accepted on edge N commits to the running best on edge N+2; Done follows the last commit.
module sad_min_tracker
  import vbsme_pkg::*;
#(
  parameter int DW    = vbsme_pkg::DW,
  parameter int LANES = vbsme_pkg::LANES,
  parameter int CNT_W = vbsme_pkg::CNT_W
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                InValid,
  input  logic                InLast,
  input  logic [LANES-1:0]    LaneEn,
  input  logic [LANES*DW-1:0] SadBus,
  input  logic [LANES*DW-1:0] IdxBus,
  output logic                InReady,
  output logic                Busy,
  output logic                Done,
  output logic [DW-1:0]       BestSad,
  output logic [DW-1:0]       BestIndex,
  output logic [CNT_W-1:0]    BeatCount
);

  state_t state, state_nxt;
  logic   accept;

  logic                in_vld, in_last;
  logic [LANES-1:0]    in_en;
  logic [LANES*DW-1:0] in_sad, in_idx;

  logic [DW-1:0] t_sad, t_idx;
  logic          t_any;

  logic          s1_vld, s1_last, s1_any;
  logic [DW-1:0] s1_sad, s1_idx;
  logic          have_best;
  logic          last_commit;

  // Start overrides state, so a beat arriving with Start is always taken.
  assign accept      = InValid && (Start || (state == ACCUM));
  assign last_commit = s1_vld && s1_last;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    Busy      = 1'b0;
    if (Start) begin
      state_nxt = (accept && InLast) ? FLUSH : ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && InLast) state_nxt = FLUSH;
        FLUSH:   if (last_commit)      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    case (state)
      ACCUM:   begin InReady = 1'b1; Busy = 1'b1; end
      FLUSH:   Busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      in_vld  <= 1'b0;
      in_last <= 1'b0;
      in_en   <= '0;
      in_sad  <= '0;
      in_idx  <= '0;
    end else begin
      in_vld <= accept;
      if (accept) begin
        in_last <= InLast;
        in_en   <= LaneEn;
        in_sad  <= SadBus;
        in_idx  <= IdxBus;
      end
    end
  end

  sad_min_tree7 #(.W(DW)) u_tree (
    .sad_bus (in_sad),
    .idx_bus (in_idx),
    .lane_en (in_en),
    .min_sad (t_sad),
    .min_idx (t_idx),
    .any_en  (t_any)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_any  <= 1'b0;
      s1_sad  <= '1;
      s1_idx  <= '0;
    end else begin
      s1_vld  <= in_vld && !Start;
      s1_last <= in_last;
      s1_any  <= t_any;
      s1_sad  <= t_sad;
      s1_idx  <= t_idx;
    end
  end

  // have_best lets an enabled all-ones SAD win when nothing smaller was seen.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      BestSad   <= '1;
      BestIndex <= '0;
      have_best <= 1'b0;
      BeatCount <= '0;
      Done      <= 1'b0;
    end else if (Start) begin
      BestSad   <= '1;
      BestIndex <= '0;
      have_best <= 1'b0;
      BeatCount <= accept ? CNT_W'(1) : '0;
      Done      <= 1'b0;
    end else begin
      if (s1_vld && s1_any && (!have_best || (s1_sad < BestSad))) begin
        BestSad   <= s1_sad;
        BestIndex <= s1_idx;
        have_best <= 1'b1;
      end
      if (accept && (BeatCount != {CNT_W{1'b1}})) BeatCount <= BeatCount + 1'b1;
      Done <= (state == FLUSH) && last_commit;
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed-vector bench for sad_min_tracker with hand-computed expectations.
module tb_sad_min_tracker;
  localparam int DW = 32;
  localparam int LN = 7;
  localparam int CW = 16;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0, InValid = 1'b0, InLast = 1'b0;
  logic [LN-1:0] LaneEn = '0;
  logic [LN*DW-1:0] SadBus = '0, IdxBus = '0;
  logic          InReady, Busy, Done;
  logic [DW-1:0] BestSad, BestIndex;
  logic [CW-1:0] BeatCount;

  int n_cmp = 0;
  int n_err = 0;

  sad_min_tracker dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InValid(InValid), .InLast(InLast),
    .LaneEn(LaneEn), .SadBus(SadBus), .IdxBus(IdxBus), .InReady(InReady),
    .Busy(Busy), .Done(Done), .BestSad(BestSad), .BestIndex(BestIndex),
    .BeatCount(BeatCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in;
    Start = 1'b0; InValid = 1'b0; InLast = 1'b0; LaneEn = '0;
  endtask

  // Background lanes carry large SADs so the lane under test is the minimum.
  task automatic fill;
    for (int k = 0; k < LN; k++) begin
      SadBus[k*DW +: DW] = DW'(1000 + k);
      IdxBus[k*DW +: DW] = DW'(900 + k);
    end
  endtask

  task automatic set_lane(input int k, input logic [DW-1:0] s, input logic [DW-1:0] i);
    SadBus[k*DW +: DW] = s;
    IdxBus[k*DW +: DW] = i;
  endtask

  task automatic beat(input logic st, input logic lst, input logic [LN-1:0] en);
    Start = st; InValid = 1'b1; InLast = lst; LaneEn = en;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    step(); step();
    n_cmp++; if (BestSad !== ONES) begin n_err++; $display("FAIL rst_best_sad: got %0h want %0h", BestSad, ONES); end
    n_cmp++; if (BestIndex !== 0) begin n_err++; $display("FAIL rst_best_idx: got %0h want 0", BestIndex); end
    n_cmp++; if (BeatCount !== 0) begin n_err++; $display("FAIL rst_count: got %0d want 0", BeatCount); end
    n_cmp++; if ({Done, Busy, InReady} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {Done, Busy, InReady}); end
    Rst = 1'b0;
    step();
  endtask

  task automatic test_single_beat;
    fill();
    for (int k = 0; k < LN; k++) IdxBus[k*DW +: DW] = DW'(100 + k);
    SadBus[0*DW +: DW] = 50; SadBus[1*DW +: DW] = 40; SadBus[2*DW +: DW] = 30;
    SadBus[3*DW +: DW] = 20; SadBus[4*DW +: DW] = 10; SadBus[5*DW +: DW] = 60;
    SadBus[6*DW +: DW] = 70;
    beat(1'b1, 1'b1, 7'h7F);
    step(); idle_in();
    n_cmp++; if ({Done, Busy, InReady} !== 3'b010) begin n_err++; $display("FAIL single_flush_flags: got %b want 010", {Done, Busy, InReady}); end
    step();
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL single_done_early: got %b want 0", Done); end
    step();
    n_cmp++; if (Done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", Done); end
    n_cmp++; if (BestSad !== 10) begin n_err++; $display("FAIL single_sad: got %0d want 10", BestSad); end
    n_cmp++; if (BestIndex !== 104) begin n_err++; $display("FAIL single_idx: got %0d want 104", BestIndex); end
    n_cmp++; if (BeatCount !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", BeatCount); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", Busy); end
    step();
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse: got %b want 0", Done); end
    n_cmp++; if (BestIndex !== 104) begin n_err++; $display("FAIL single_hold_idx: got %0d want 104", BestIndex); end
  endtask

  task automatic test_multi_beat(input logic [DW-1:0] third, input logic [DW-1:0] e_sad,
                                 input logic [DW-1:0] e_idx);
    fill(); set_lane(0, 25, 5);
    beat(1'b1, 1'b0, 7'h7F);
    step();
    fill(); set_lane(3, 25, 9);
    beat(1'b0, 1'b0, 7'h7F);
    step();
    fill(); set_lane(6, third, 20);
    beat(1'b0, 1'b1, 7'h7F);
    step(); idle_in();
    step(); step();
    n_cmp++; if (Done !== 1'b1) begin n_err++; $display("FAIL multi_done_%0d: got %b want 1", third, Done); end
    n_cmp++; if (BestSad !== e_sad) begin n_err++; $display("FAIL multi_sad_%0d: got %0d want %0d", third, BestSad, e_sad); end
    n_cmp++; if (BestIndex !== e_idx) begin n_err++; $display("FAIL multi_idx_%0d: got %0d want %0d", third, BestIndex, e_idx); end
    n_cmp++; if (BeatCount !== 3) begin n_err++; $display("FAIL multi_count_%0d: got %0d want 3", third, BeatCount); end
    step();
  endtask

  task automatic test_lane_tie(input logic [LN-1:0] en, input logic [DW-1:0] e_idx);
    fill(); set_lane(2, 8, 202); set_lane(4, 8, 204);
    beat(1'b1, 1'b1, en);
    step(); idle_in();
    step(); step();
    n_cmp++; if (BestSad !== 8) begin n_err++; $display("FAIL tie_sad_%h: got %0d want 8", en, BestSad); end
    n_cmp++; if (BestIndex !== e_idx) begin n_err++; $display("FAIL tie_idx_%h: got %0d want %0d", en, BestIndex, e_idx); end
    step();
  endtask

  task automatic test_lane_mask_zero;
    fill(); set_lane(1, 40, 7);
    beat(1'b1, 1'b0, 7'h7F);
    step();
    fill(); set_lane(0, 1, 3);
    beat(1'b0, 1'b1, 7'h00);
    step(); idle_in();
    step(); step();
    n_cmp++; if (Done !== 1'b1) begin n_err++; $display("FAIL mask0_done: got %b want 1", Done); end
    n_cmp++; if (BestSad !== 40) begin n_err++; $display("FAIL mask0_sad: got %0d want 40", BestSad); end
    n_cmp++; if (BestIndex !== 7) begin n_err++; $display("FAIL mask0_idx: got %0d want 7", BestIndex); end
    n_cmp++; if (BeatCount !== 2) begin n_err++; $display("FAIL mask0_count: got %0d want 2", BeatCount); end
    step();
  endtask

  task automatic test_all_ones;
    fill(); set_lane(5, ONES, 55);
    beat(1'b1, 1'b1, 7'h20);
    step(); idle_in();
    step(); step();
    n_cmp++; if (BestSad !== ONES) begin n_err++; $display("FAIL ones_sad: got %0h want %0h", BestSad, ONES); end
    n_cmp++; if (BestIndex !== 55) begin n_err++; $display("FAIL ones_idx: got %0d want 55", BestIndex); end
    step();
  endtask

  task automatic test_restart;
    int dones;
    dones = 0;
    fill(); set_lane(0, 5, 1);
    beat(1'b1, 1'b0, 7'h7F);
    step();
    fill(); set_lane(0, 3, 2);
    beat(1'b0, 1'b0, 7'h7F);
    step();
    fill(); set_lane(0, 99, 77);
    beat(1'b1, 1'b1, 7'h7F);
    step(); idle_in();
    for (int c = 0; c < 6; c++) begin
      if (Done === 1'b1) dones++;
      step();
    end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL restart_dones: got %0d want 1", dones); end
    n_cmp++; if (BestSad !== 99) begin n_err++; $display("FAIL restart_sad: got %0d want 99", BestSad); end
    n_cmp++; if (BestIndex !== 77) begin n_err++; $display("FAIL restart_idx: got %0d want 77", BestIndex); end
    n_cmp++; if (BeatCount !== 1) begin n_err++; $display("FAIL restart_count: got %0d want 1", BeatCount); end
  endtask

  task automatic test_async_reset;
    int dones;
    dones = 0;
    fill(); set_lane(0, 7, 70);
    beat(1'b1, 1'b0, 7'h7F);
    step();
    beat(1'b0, 1'b1, 7'h7F);
    step(); idle_in();
    #2 Rst = 1'b1;
    #1;
    n_cmp++; if (BestSad !== ONES) begin n_err++; $display("FAIL arst_sad: got %0h want %0h", BestSad, ONES); end
    n_cmp++; if ({Busy, InReady} !== 2'b00) begin n_err++; $display("FAIL arst_flags: got %b want 00", {Busy, InReady}); end
    n_cmp++; if (BeatCount !== 0) begin n_err++; $display("FAIL arst_count: got %0d want 0", BeatCount); end
    step();
    Rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (Done === 1'b1) dones++;
      step();
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL arst_no_done: got %0d want 0", dones); end
  endtask

  task automatic test_backpressure;
    fill(); set_lane(0, 60, 61);
    beat(1'b1, 1'b1, 7'h7F);
    step();
    fill(); set_lane(0, 1, 2);
    beat(1'b0, 1'b1, 7'h7F);
    n_cmp++; if (InReady !== 1'b0) begin n_err++; $display("FAIL bp_flush_ready: got %b want 0", InReady); end
    step(); step();
    n_cmp++; if (Done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", Done); end
    n_cmp++; if (BestSad !== 60) begin n_err++; $display("FAIL bp_flush_sad: got %0d want 60", BestSad); end
    n_cmp++; if (BeatCount !== 1) begin n_err++; $display("FAIL bp_flush_count: got %0d want 1", BeatCount); end
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if ({Done, Busy, InReady} !== 3'b000) begin n_err++; $display("FAIL bp_idle_flags: got %b want 000", {Done, Busy, InReady}); end
    n_cmp++; if (BestSad !== 60) begin n_err++; $display("FAIL bp_idle_sad: got %0d want 60", BestSad); end
    n_cmp++; if (BestIndex !== 61) begin n_err++; $display("FAIL bp_idle_idx: got %0d want 61", BestIndex); end
    n_cmp++; if (BeatCount !== 1) begin n_err++; $display("FAIL bp_idle_count: got %0d want 1", BeatCount); end
    idle_in();
    step();
  endtask

  initial begin
    idle_in();
    fill();
    test_reset();
    test_single_beat();
    test_multi_beat(12, 12, 20);
    test_multi_beat(30, 25, 5);
    test_lane_tie(7'h7F, 202);
    test_lane_tie(7'h7B, 204);
    test_lane_mask_zero();
    test_all_ones();
    test_restart();
    test_async_reset();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
